// File: rtl/cpu_ctrl_fsm_if.sv
// cpu_ctrl_fsm_if: decoder flags, branch result and memory handshake into the
// control sequencer, plus every datapath enable and select it drives.
interface cpu_ctrl_fsm_if #(parameter int CNT_W = 32);
    logic is_alu_reg, is_alu_imm, is_branch, is_jal, is_jalr;
    logic is_lui, is_auipc, is_load, is_store, is_system;
    logic br_taken, mem_ready;
    logic mem_req, mem_we, addr_sel, ir_we, mdr_we, pc_we;
    logic [1:0] pc_sel;
    logic alu_a_sel, alu_b_sel, rf_we;
    logic [1:0] wb_sel;
    logic halted, illegal;
    logic [CNT_W-1:0] instret;
    modport master (
        input  is_alu_reg, is_alu_imm, is_branch, is_jal, is_jalr,
               is_lui, is_auipc, is_load, is_store, is_system, br_taken, mem_ready,
        output mem_req, mem_we, addr_sel, ir_we, mdr_we, pc_we, pc_sel,
               alu_a_sel, alu_b_sel, rf_we, wb_sel, halted, illegal, instret
    );
    modport slave (
        output is_alu_reg, is_alu_imm, is_branch, is_jal, is_jalr,
               is_lui, is_auipc, is_load, is_store, is_system, br_taken, mem_ready,
        input  mem_req, mem_we, addr_sel, ir_we, mdr_we, pc_we, pc_sel,
               alu_a_sel, alu_b_sel, rf_we, wb_sel, halted, illegal, instret
    );
endinterface

// File: rtl/cpu_ctrl_fsm.sv
// cpu_ctrl_fsm: multi-cycle RV32I control sequencer with halt detection and
// retired-instruction counter.
module cpu_ctrl_fsm #(parameter int CNT_W = 32) (
    input logic clk,
    input logic rst,
    cpu_ctrl_fsm_if.master bus
);
    typedef enum logic [2:0] {FETCH, DECODE, EXECUTE, MEM, WB, HALT} state_t;
    state_t state, nxt;
    logic [9:0] f, p;
    logic sel_a, sel_b, ill;
    logic [CNT_W-1:0] cnt;
    // p keeps only the highest-priority flag so a malformed decoder still yields one class
    assign f = {bus.is_alu_reg, bus.is_alu_imm, bus.is_auipc, bus.is_lui, bus.is_jalr,
                bus.is_jal, bus.is_branch, bus.is_store, bus.is_load, bus.is_system};
    assign p = f & (~f + 10'd1);
    assign sel_a = p[7];
    assign sel_b = p[8] | p[1] | p[2] | p[5] | p[7];
    assign bus.illegal = ill;
    assign bus.instret = cnt;
    always_comb begin
        nxt = state;
        bus.mem_req = 1'b0;
        bus.mem_we = 1'b0;
        bus.addr_sel = 1'b0;
        bus.ir_we = 1'b0;
        bus.mdr_we = 1'b0;
        bus.pc_we = 1'b0;
        bus.pc_sel = 2'b00;
        bus.alu_a_sel = 1'b0;
        bus.alu_b_sel = 1'b0;
        bus.rf_we = 1'b0;
        bus.wb_sel = 2'b00;
        bus.halted = 1'b0;
        if (!rst)
            case (state)
                FETCH: begin
                    bus.mem_req = 1'b1;
                    bus.ir_we = bus.mem_ready;
                    nxt = bus.mem_ready ? DECODE : FETCH;
                end
                DECODE: nxt = (f == '0 || p[0]) ? HALT : EXECUTE;
                EXECUTE: begin
                    bus.alu_a_sel = sel_a;
                    bus.alu_b_sel = sel_b;
                    bus.pc_we = p[3];
                    bus.pc_sel = {1'b0, p[3] & bus.br_taken};
                    nxt = (p[1] | p[2]) ? MEM : p[3] ? FETCH : WB;
                end
                MEM: begin
                    bus.mem_req = 1'b1;
                    bus.addr_sel = 1'b1;
                    bus.mem_we = p[2];
                    bus.alu_a_sel = sel_a;
                    bus.alu_b_sel = sel_b;
                    bus.mdr_we = bus.mem_ready & p[1];
                    bus.pc_we = bus.mem_ready & ~p[1];
                    nxt = !bus.mem_ready ? MEM : p[1] ? WB : FETCH;
                end
                WB: begin
                    bus.rf_we = 1'b1;
                    bus.pc_we = 1'b1;
                    bus.wb_sel = p[1] ? 2'b01 : (p[4] | p[5]) ? 2'b10 : p[6] ? 2'b11 : 2'b00;
                    bus.pc_sel = p[4] ? 2'b01 : p[5] ? 2'b10 : 2'b00;
                    nxt = FETCH;
                end
                HALT: bus.halted = 1'b1;
                default: nxt = FETCH;
            endcase
    end
    // every retiring transition is exactly the one that updates the PC
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= FETCH;
            ill <= 1'b0;
            cnt <= '0;
        end else begin
            state <= nxt;
            if (state == DECODE && f == '0) ill <= 1'b1;
            if (bus.pc_we) cnt <= cnt + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// tb_cpu_ctrl_fsm: scoreboard bench; per-cycle expected control vectors are queued
// with the stimulus and compared against the observed outputs.
module tb_cpu_ctrl_fsm;
    localparam int SYS = 0, LD = 1, ST = 2, BR = 3, JAL = 4, JALR = 5;
    localparam int LUI = 6, AUIPC = 7, IMM = 8, REG = 9;
    localparam logic [13:0] REQ = 14'h2000, WE = 14'h1000, AS = 14'h0800, IR = 14'h0400;
    localparam logic [13:0] MDR = 14'h0200, PCW = 14'h0100, AA = 14'h0020, AB = 14'h0010;
    localparam logic [13:0] RF = 14'h0008, HLT = 14'h0001;

    typedef struct packed {
        logic rdy;
        logic [9:0] fl;
        logic br;
    } stim_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [9:0] fl = '0;
    logic br = 1'b0;
    logic rdy = 1'b0;
    int checks = 0;
    int failures = 0;
    stim_t stim_q[$];
    logic [13:0] exp_q[$];
    logic [13:0] obs_q[$];
    logic [13:0] o_vec;

    cpu_ctrl_fsm_if #(.CNT_W(32)) i32 ();
    cpu_ctrl_fsm_if #(.CNT_W(4)) i4 ();

    cpu_ctrl_fsm #(.CNT_W(32)) dut (.clk(clk), .rst(rst), .bus(i32));
    cpu_ctrl_fsm #(.CNT_W(4)) dut_small (.clk(clk), .rst(rst), .bus(i4));

    assign {i32.is_alu_reg, i32.is_alu_imm, i32.is_auipc, i32.is_lui, i32.is_jalr,
            i32.is_jal, i32.is_branch, i32.is_store, i32.is_load, i32.is_system} = fl;
    assign {i4.is_alu_reg, i4.is_alu_imm, i4.is_auipc, i4.is_lui, i4.is_jalr,
            i4.is_jal, i4.is_branch, i4.is_store, i4.is_load, i4.is_system} = fl;
    assign i32.br_taken = br;
    assign i32.mem_ready = rdy;
    assign i4.br_taken = br;
    assign i4.mem_ready = rdy;
    assign o_vec = {i32.mem_req, i32.mem_we, i32.addr_sel, i32.ir_we, i32.mdr_we, i32.pc_we,
                    i32.pc_sel, i32.alu_a_sel, i32.alu_b_sel, i32.rf_we, i32.wb_sel, i32.halted};

    always #5 clk = ~clk;

    function automatic logic [13:0] ps(input logic [1:0] s);
        return {6'b0, s, 6'b0};
    endfunction

    function automatic logic [13:0] wbs(input logic [1:0] s);
        return {11'b0, s, 1'b0};
    endfunction

    function automatic logic [9:0] fb(input int k);
        return 10'(1) << k;
    endfunction

    task automatic add(input logic r, input logic [9:0] f, input logic b, input logic [13:0] e);
        stim_q.push_back('{r, f, b});
        exp_q.push_back(e);
    endtask

    // expected trace of one instruction, written from the sequencer's cycle table
    task automatic push_instr(input logic [9:0] f, input logic b, input int fw, input int mw,
                              input int hc);
        int c = 10;
        logic [13:0] m;
        for (int k = 0; k < 10; k++) if (f[k] && c == 10) c = k;
        for (int k = 0; k < fw; k++) add(1'b0, f, b, REQ);
        add(1'b1, f, b, REQ | IR);
        add(1'($urandom_range(0, 1)), f, b, 14'h0);
        if (c == 10 || c == SYS) begin
            for (int k = 0; k < hc; k++) add(1'($urandom_range(0, 1)), f, b, HLT);
        end else if (c == LD || c == ST) begin
            m = REQ | AS | AB | ((c == ST) ? WE : 14'h0);
            add(1'($urandom_range(0, 1)), f, b, AB);
            for (int k = 0; k < mw; k++) add(1'b0, f, b, m);
            add(1'b1, f, b, m | ((c == LD) ? MDR : PCW));
            if (c == LD) add(1'($urandom_range(0, 1)), f, b, RF | PCW | wbs(2'b01));
        end else if (c == BR) begin
            add(1'($urandom_range(0, 1)), f, b, PCW | ps(b ? 2'b01 : 2'b00));
        end else begin
            m = (c == IMM || c == JALR) ? AB : (c == AUIPC) ? (AA | AB) : 14'h0;
            add(1'($urandom_range(0, 1)), f, b, m);
            m = RF | PCW;
            m |= (c == LUI) ? wbs(2'b11) : (c == JAL || c == JALR) ? wbs(2'b10) : 14'h0;
            m |= (c == JAL) ? ps(2'b01) : (c == JALR) ? ps(2'b10) : 14'h0;
            add(1'($urandom_range(0, 1)), f, b, m);
        end
    endtask

    task automatic play();
        stim_t s;
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            @(negedge clk);
            fl = s.fl;
            br = s.br;
            rdy = s.rdy;
            #1 obs_q.push_back(o_vec);
        end
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        rst = 1'b1;
        rdy = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [13:0] e, o;
        int n = 0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (o_vec !== 14'h0) begin failures++; $display("FAIL reset_outputs got=%h exp=%h", o_vec, 14'h0); end
        checks++;
        if (i32.instret !== 32'd0 || i32.illegal !== 1'b0) begin
            failures++; $display("FAIL reset_regs instret=%0d illegal=%b exp 0/0", i32.instret, i32.illegal);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (o_vec !== REQ) begin failures++; $display("FAIL reset_first_fetch got=%h exp=%h", o_vec, REQ); end
        push_instr(fb(LD), 1'b0, 0, 5, 0);
        while (stim_q.size() > 4) begin void'(stim_q.pop_back()); void'(exp_q.pop_back()); end
        play();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin failures++; $display("FAIL reset_pre_mem cyc=%0d got=%h exp=%h", n, o, e); end
            n++;
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (i32.mem_req !== 1'b0) begin failures++; $display("FAIL reset_async_mem_req got=%b exp=0", i32.mem_req); end
        @(negedge clk);
        rst = 1'b0;
        rdy = 1'b0;
        #1;
        checks++;
        if (o_vec !== REQ || i32.instret !== 32'd0) begin
            failures++; $display("FAIL reset_mid_mem got=%h instret=%0d exp=%h instret=0", o_vec, i32.instret, REQ);
        end
    endtask

    task automatic test_zero_wait();
        logic [13:0] e, o;
        int n = 0;
        push_instr(fb(REG), 1'b0, 0, 0, 0);
        push_instr(fb(IMM), 1'b0, 0, 0, 0);
        push_instr(fb(LUI), 1'b0, 0, 0, 0);
        push_instr(fb(AUIPC), 1'b0, 0, 0, 0);
        push_instr(fb(JAL), 1'b0, 0, 0, 0);
        push_instr(fb(JALR), 1'b0, 0, 0, 0);
        play();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin failures++; $display("FAIL zero_wait cyc=%0d got=%h exp=%h", n, o, e); end
            n++;
        end
        @(posedge clk);
        #1;
        checks++;
        if (i32.instret !== 32'd6) begin failures++; $display("FAIL zero_wait_instret got=%0d exp=6", i32.instret); end
    endtask

    task automatic test_load_wait();
        logic [13:0] e, o;
        int n = 0;
        push_instr(fb(LD), 1'b0, 0, 2, 0);
        checks++;
        if (exp_q.size() != 7) begin failures++; $display("FAIL load_len got=%0d exp=7", exp_q.size()); end
        play();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin failures++; $display("FAIL load_wait cyc=%0d got=%h exp=%h", n, o, e); end
            n++;
        end
        @(posedge clk);
        #1;
        checks++;
        if (i32.instret !== 32'd7) begin failures++; $display("FAIL load_instret got=%0d exp=7", i32.instret); end
    endtask

    task automatic test_store_branch();
        logic [13:0] e, o;
        int n = 0;
        push_instr(fb(ST), 1'b0, 1, 0, 0);
        push_instr(fb(BR), 1'b1, 0, 0, 0);
        push_instr(fb(BR), 1'b0, 0, 0, 0);
        push_instr(fb(LD) | fb(REG), 1'b0, 0, 0, 0);
        push_instr(fb(ST) | fb(BR), 1'b1, 0, 1, 0);
        play();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin failures++; $display("FAIL store_branch cyc=%0d got=%h exp=%h", n, o, e); end
            n++;
        end
        @(posedge clk);
        #1;
        checks++;
        if (i32.instret !== 32'd12) begin failures++; $display("FAIL store_branch_instret got=%0d exp=12", i32.instret); end
    endtask

    task automatic test_halt();
        logic [13:0] e, o;
        int n = 0;
        push_instr(fb(SYS) | fb(LD), 1'b0, 0, 0, 20);
        play();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin failures++; $display("FAIL halt_system cyc=%0d got=%h exp=%h", n, o, e); end
            n++;
        end
        checks++;
        if (i32.illegal !== 1'b0 || i32.instret !== 32'd12) begin
            failures++; $display("FAIL halt_system_regs illegal=%b instret=%0d exp 0/12", i32.illegal, i32.instret);
        end
        reset_pulse();
        push_instr(10'h0, 1'b0, 0, 0, 20);
        play();
        n = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin failures++; $display("FAIL halt_illegal cyc=%0d got=%h exp=%h", n, o, e); end
            n++;
        end
        checks++;
        if (i32.illegal !== 1'b1 || i32.instret !== 32'd0) begin
            failures++; $display("FAIL halt_illegal_regs illegal=%b instret=%0d exp 1/0", i32.illegal, i32.instret);
        end
        reset_pulse();
        #1;
        checks++;
        if (i32.illegal !== 1'b0 || o_vec !== REQ) begin
            failures++; $display("FAIL halt_cleared illegal=%b got=%h exp 0/%h", i32.illegal, o_vec, REQ);
        end
    endtask

    task automatic test_wrap();
        logic [13:0] e, o;
        int n = 0;
        for (int k = 0; k < 17; k++) push_instr(fb(IMM), 1'b0, 0, 0, 0);
        play();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin failures++; $display("FAIL wrap_trace cyc=%0d got=%h exp=%h", n, o, e); end
            n++;
        end
        @(posedge clk);
        #1;
        checks++;
        if (i4.instret !== 4'd1) begin failures++; $display("FAIL wrap_small got=%0d exp=1", i4.instret); end
        checks++;
        if (i32.instret !== 32'd17) begin failures++; $display("FAIL wrap_wide got=%0d exp=17", i32.instret); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_zero_wait();
        test_load_wait();
        test_store_branch();
        test_halt();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/cpu_ctrl_fsm.md
# cpu_ctrl_fsm

Multi-cycle control sequencer for the simple RV32I core. It takes the per-class flags from the instruction `decoder`, the branch-compare result and a single-port memory handshake. It steps the shared datapath through fetch, decode, execute, memory and writeback, driving every register-enable and mux-select. It also halts the core on SYSTEM or unrecognised instructions and counts retired instructions.

## Interface
- `CNT_W`, 32: width of the retired-instruction counter.

Ports:
- `clk`  in  1  core clock; all state changes on its rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `is_alu_reg`, `is_alu_imm`, `is_branch`, `is_jal`, `is_jalr`, `is_lui`, `is_auipc`, `is_load`, `is_store`, `is_system`  in  1 each  decoder flags, computed from the IR, stable after FETCH.
- `br_taken`  in  1  branch comparator result, valid in EXECUTE.
- `mem_ready`  in  1  memory has accepted or completed the current request this cycle.
- `mem_req`  out  1  memory request.
- `mem_we`  out  1  write strobe, qualified by `mem_req`.
- `addr_sel`  out  1  memory address source: 0 = PC, 1 = ALU result.
- `ir_we`  out  1  load IR from memory read data.
- `mdr_we`  out  1  load data register from memory read data.
- `pc_we`  out  1  PC update.
- `pc_sel`  out  2  PC source: 00 = PC+4, 01 = PC+imm, 10 = (rs1+imm) & ~1.
- `alu_a_sel`  out  1  ALU operand A: 0 = rs1, 1 = PC.
- `alu_b_sel`  out  1  ALU operand B: 0 = rs2, 1 = imm.
- `rf_we`  out  1  register-file write.
- `wb_sel`  out  2  writeback source: 00 = ALU, 01 = MDR, 10 = PC+4, 11 = imm.
- `halted`  out  1  core stopped.
- `illegal`  out  1  the stop was caused by an instruction that raised no decoder flag.
- `instret`  out  `CNT_W`  retired-instruction count.

## Operation
- States: FETCH, DECODE, EXECUTE, MEM, WB, HALT. Encoding is free.
- **FETCH**
  - Drives `mem_req`=1, `addr_sel`=0.
  - If `mem_ready`: `ir_we`=1, go to DECODE. Otherwise hold FETCH with `mem_req` kept high.
- **DECODE**
  - Register-read cycle; no enables asserted.
  - `is_system` → HALT.
  - No flag set → HALT and set `illegal`.
  - Otherwise → EXECUTE.
- **EXECUTE**
  - `alu_a_sel`=1 only for `is_auipc`.
  - `alu_b_sel`=1 for alu_imm, load, store, jalr, auipc. `alu_b_sel`=0 for alu_reg and branch.
  - Load or store → MEM.
  - Branch: `pc_we`=1, `pc_sel`=01 if `br_taken` else 00, retire, go to FETCH.
  - All other classes → WB.
- **MEM**
  - Drives `mem_req`=1, `addr_sel`=1, `mem_we`=`is_store`. ALU operand selects are held as in EXECUTE.
  - Wait while `mem_ready`=0, with request signals held stable.
  - On `mem_ready` with a load: `mdr_we`=1, go to WB.
  - On `mem_ready` with a store: `pc_we`=1, `pc_sel`=00, retire, go to FETCH.
- **WB**
  - `rf_we`=1.
  - `wb_sel`: 00 for alu_reg/alu_imm/auipc, 01 for load, 10 for jal/jalr, 11 for lui.
  - `pc_we`=1 with `pc_sel` = 01 for jal, 10 for jalr, 00 otherwise.
  - Retire, go to FETCH.
- **HALT**
  - `halted`=1. All enables and `mem_req` are 0.
  - Absorbing until `rst`. `instret` frozen.
- **Retire**: `instret` <= `instret`+1, modulo 2^`CNT_W` (all-ones wraps to 0). SYSTEM and illegal instructions do not retire.
- Flag priority when several flags are set (a malformed decoder): system > load > store > branch > jal > jalr > lui > auipc > alu_imm > alu_reg.
- All outputs not listed for a state are 0 in that state.

## Timing
- Outputs are combinational from the current state and the inputs (Moore plus `mem_ready`/`br_taken` qualification). `illegal` and `instret` are registered.
- Reset values: state FETCH, `instret`=0, `illegal`=0, `halted`=0. All enables read 0 while `rst`=1.
- Asserting `rst` mid-instruction aborts it immediately, with no retire. `mem_req` drops asynchronously.
- After `rst` deasserts, the first cycle is FETCH with `mem_req`=1.
- Latency with `mem_ready` tied 1, FETCH to next FETCH:
  - branch: 3 cycles.
  - ALU, lui, auipc, jal, jalr, store: 4 cycles.
  - load: 5 cycles.
- Each memory wait cycle adds one cycle.
- `mem_ready` is ignored outside FETCH and MEM.

## Test plan
- **Reset:** `rst` pulse for 2 cycles → `mem_req`=1 on the first cycle after release; `instret`=0. Pulsing `rst` while in MEM → `mem_req`=0 in the same cycle and the state returns to FETCH.
- **Zero-wait sequence:** `add`, `addi`, `lui`, `auipc`, `jal`, `jalr` (`mem_ready`=1) → each takes 4 cycles, with `wb_sel` = 00, 00, 11, 00, 10, 10 and `pc_sel` = 00, 00, 00, 00, 01, 10 in WB. `instret`=6.
- **Load with wait states:** `lw` with `mem_ready` low for 2 MEM cycles → `mem_req`, `addr_sel`=1, `mem_we`=0 held for 3 cycles, `mdr_we` pulses once, then WB with `wb_sel`=01. Total 7 cycles.
- **Store and branch:** `sw` → `mem_we`=1 in MEM, no `rf_we`, `pc_sel`=00. `beq` with `br_taken`=1 → `pc_sel`=01 in EXECUTE. With `br_taken`=0 → `pc_sel`=00. Both take 3 cycles and neither asserts `rf_we`.
- **Halt paths:** `ebreak` (`is_system`) → `halted`=1 after DECODE, `illegal`=0, `instret` unchanged. Instruction word 0x00000000 (no flags) → `halted`=1, `illegal`=1. Core stays halted for 20 cycles until `rst`.
- **Counter wrap:** `CNT_W`=4, 17 `addi` → `instret`=1 after wrap.
